imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Controller that owns the write side of the 32-bit instruction memory and gates CPU fetch.
//  After reset it zero-fills the memory, accepts a program as a valid/ready word stream, then releases the CPU.
//  Sits between the boot/test loader, the instruction memory array and the single-cycle fetch stage (PC -> Instruction).
// PARAMETERS
//  DEPTH   64  instruction words in memory
//  ADDR_W  6   word-address width, clog2(DEPTH)
//  DATA_W  32  instruction width
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous, active-low reset
//  reload      in   1       pulse: discard program, return to CLEAR
//  ld_valid    in   1       loader word valid
//  ld_ready    out  1       controller accepts word
//  ld_data     in   DATA_W  instruction word
//  ld_last     in   1       qualifies final word of program
//  cpu_addr    in   32      fetch byte address (PC)
//  cpu_instr   out  DATA_W  fetched instruction
//  cpu_stall   out  1       CPU must hold PC / not commit
//  load_cnt    out  ADDR_W+1  words loaded in current program
//  mem_we      out  1       memory write enable
//  mem_waddr   out  ADDR_W  memory write word address
//  mem_wdata   out  DATA_W  memory write data
//  mem_raddr   out  ADDR_W  memory read word address (async read)
//  mem_rdata   in   DATA_W  memory read data
// BEHAVIOUR
//  Reset: state=CLEAR, ptr=0, load_cnt=0; ld_ready=0, cpu_stall=1, cpu_instr=0, mem_we=0.
//  FSM: CLEAR -> LOAD -> RUN; reload (any state) -> CLEAR next cycle, highest priority.
//  CLEAR: mem_we=1, mem_waddr=ptr, mem_wdata=0; ptr++ each cycle; after ptr==DEPTH-1 write -> LOAD, ptr=0. DEPTH cycles.
//  LOAD: ld_ready=1 while ptr<=DEPTH-1. Handshake (ld_valid&ld_ready) writes ld_data at ptr same cycle
//   (mem_we comb = handshake); ptr++, load_cnt++. -> RUN after handshake with ld_last=1 or after word DEPTH-1 (full).
//  Full: word DEPTH-1 accepted without ld_last -> RUN; ld_ready=0 from then; extra words never accepted.
//  Zero-length program impossible; ld_last on first word gives load_cnt=1.
//  RUN: cpu_stall=0, mem_we=0, ld_ready=0; cpu_instr = mem_rdata (combinational, zero latency).
//  Non-RUN: cpu_instr=0 (NOP), cpu_stall=1.
//  mem_raddr = cpu_addr[ADDR_W+1:2] always.
//  reload concurrent with a LOAD handshake: word is NOT written (mem_we suppressed), go to CLEAR, load_cnt=0.
//  load_cnt holds final value in RUN; cleared on entering CLEAR.
//  Async reset mid-CLEAR/LOAD aborts immediately; memory contents then undefined until next CLEAR completes.
// CONFIGURATION
//  IMEM_FETCH_CHECK_EN defined: adds output fetch_err (1 bit, reset 0). In RUN, cpu_addr[1:0]!=0 or
//   cpu_addr[31:2]>=DEPTH sets fetch_err (sticky until reload/reset) and forces cpu_instr=0 that cycle.
//  Not defined: no fetch_err port; low two address bits ignored, upper bits truncated (address wraps mod DEPTH*4).
// STRUCTURE
//  Shared package imem_pkg: state encoding CLEAR=2'd0, LOAD=2'd1, RUN=2'd2; NOP_INSTR=32'h0000_0000;
//   DEPTH/ADDR_W defaults.
//  No sub-module needed; memory array stays external (instantiated alongside, driven through mem_* ports).
// TESTING
//  Reset, hold 70 cycles -> exactly 64 zero writes, addr 0..63; cpu_stall=1 throughout CLEAR; LOAD on cycle 65.
//  Load 3 words 0x20080005,0x20090003,0x01095020 (last on 3rd) -> RUN; cpu_addr=8 gives 0x01095020, load_cnt=3.
//  ld_valid toggled 1-0-1 with 4 words -> only handshake cycles write; addresses 0..3 contiguous.
//  Stream 70 words, no ld_last -> 64 accepted, ld_ready=0 after word 63, RUN, load_cnt=64.
//  reload asserted with handshake on word 2 -> word 2 not written, CLEAR restarts, load_cnt=0, stall=1.
//  IMEM_FETCH_CHECK_EN: RUN, cpu_addr=0x6 -> fetch_err=1, cpu_instr=0; cpu_addr=0x100 also errs; reload clears fetch_err.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_pkg : shared state encoding and sizing for the instruction-memory      |
// |            load controller.                                                 |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package imem_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_load_ctrl_if : loader stream, CPU fetch and memory-port bundle.        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface imem_load_ctrl_if #(
  parameter int ADDR_W = imem_pkg::IMEM_ADDR_W,
  parameter int DATA_W = imem_pkg::IMEM_DATA_W
);

  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_stall;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
    output ld_ready, cpu_instr, cpu_stall, mem_we, mem_waddr, mem_wdata, mem_raddr
  );

  modport slave (
    output ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
    input  ld_ready, cpu_instr, cpu_stall, mem_we, mem_waddr, mem_wdata, mem_raddr
  );

endinterface
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_load_ctrl : zero-fills the instruction memory, loads a program from a  |
// |                  valid/ready stream, then releases CPU fetch.               |
// | Option   : IMEM_FETCH_CHECK_EN adds the sticky fetch_err output.            |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        reload,
  imem_load_ctrl_if.master bus,
`ifdef IMEM_FETCH_CHECK_EN
  output logic             fetch_err,
`endif
  output logic [ADDR_W:0]  load_cnt
);

  localparam logic [ADDR_W-1:0] C_PTR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    w_hs          = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.cpu_stall = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = ptr_q;
    bus.mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        // No zero-fill write may escape while reset is still held.
        bus.mem_we = rst_n;
        ptr_d      = ptr_q + ADDR_W'(1);
        if (ptr_q == C_PTR_LAST) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        bus.ld_ready = 1'b1;
        w_hs         = bus.ld_valid & ~reload;
        if (w_hs) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = bus.ld_data;
          ptr_d         = ptr_q + ADDR_W'(1);
          cnt_d         = cnt_q + (ADDR_W + 1)'(1);
          if (bus.ld_last || (ptr_q == C_PTR_LAST)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        bus.cpu_stall = 1'b0;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    if (reload) begin
      state_d = CLEAR;
      ptr_d   = '0;
      cnt_d   = '0;
    end
  end

  assign bus.mem_raddr = bus.cpu_addr[ADDR_W+1:2];
  assign load_cnt      = cnt_q;

`ifdef IMEM_FETCH_CHECK_EN
  logic w_bad_addr;
  logic fetch_err_q, fetch_err_d;

  assign w_bad_addr = (bus.cpu_addr[1:0] != 2'b00) || (bus.cpu_addr[31:2] >= 30'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    fetch_err_d   = fetch_err_q | ((state_q == RUN) & w_bad_addr);
    bus.cpu_instr = DATA_W'(NOP_INSTR);
    if (reload) begin
      fetch_err_d = 1'b0;
    end
    if ((state_q == RUN) && !w_bad_addr) begin
      bus.cpu_instr = bus.mem_rdata;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  // Address bits outside the word index are deliberately ignored (wrap).
  logic [31-ADDR_W:0] w_unused_addr;
  assign w_unused_addr = {bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

  always_comb begin
    bus.cpu_instr = DATA_W'(NOP_INSTR);
    if (state_q == RUN) begin
      bus.cpu_instr = bus.mem_rdata;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_load_ctrl : directed/random bench with a word-level memory model.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int DEPTH = IMEM_DEPTH;

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 reload = 1'b0;
  logic [IMEM_ADDR_W:0] load_cnt;
`ifdef IMEM_FETCH_CHECK_EN
  logic                 fetch_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  imem_load_ctrl_if bus ();

  imem_load_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reload   (reload),
    .bus      (bus),
`ifdef IMEM_FETCH_CHECK_EN
    .fetch_err(fetch_err),
`endif
    .load_cnt (load_cnt)
  );

  always #5 clk = ~clk;

  // External instruction memory: synchronous write, asynchronous read.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_raddr];

  // Reference: program words offered, expected memory image, observed write log.
  logic [31:0] ld_words [80];
  logic [31:0] exp_mem  [DEPTH];
  logic [5:0]  wa_q [$];
  logic [31:0] wd_q [$];
  logic        s_ready, s_we, s_stall;
  int          we_bad, full_bad, stall_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    #1;
    s_ready = bus.ld_ready;
    s_we    = bus.mem_we;
    s_stall = bus.cpu_stall;
    if (s_we === 1'b1) begin
      wa_q.push_back(bus.mem_waddr);
      wd_q.push_back(bus.mem_wdata);
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_addr(input int i);
    logic [31:0] a;
`ifdef IMEM_FETCH_CHECK_EN
    a = 32'(i) << 2;
`else
    a      = $urandom;
    a[7:2] = 6'(i);
`endif
    return a;
  endfunction

  task automatic chk_log(input string tag, input int base, input int n, input bit zeros);
    int bad;
    bad = 0;
    for (int j = 0; j < n; j++) begin
      if (base + j >= wa_q.size()) bad++;
      else if (wa_q[base+j] !== 6'(j) || wd_q[base+j] !== (zeros ? 32'h0 : ld_words[j])) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    stall_bad = 0;
    sample();
    while (s_ready !== 1'b1 && n < 200) begin
      if (s_stall !== 1'b1) stall_bad++;
      n++;
      @(posedge clk);
      @(negedge clk);
      sample();
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_clr_cycles"}, n, DEPTH);
    chk({tag, "_clr_stall"}, stall_bad, 0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
  endtask

  task automatic reload_clear(input string tag);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk({tag, "_rl_stall"}, bus.cpu_stall, 1'b1);
    chk({tag, "_rl_cnt"}, load_cnt, 0);
    chk({tag, "_rl_instr"}, bus.cpu_instr, 32'h0);
    wa_q.delete();
    wd_q.delete();
    wait_clear(tag);
    chk({tag, "_clr_nwr"}, wa_q.size(), DEPTH);
    chk_log({tag, "_clr_log"}, 0, DEPTH, 1'b1);
  endtask

  // mode 0: valid every cycle, 1: valid toggles 1-0-1, 2: random gaps.
  task automatic do_load(input int n, input int last_idx, input int mode, input bit given,
                         output int acc);
    int  cyc;
    logic v;
    acc = 0; cyc = 0; we_bad = 0; full_bad = 0;
    if (!given) for (int i = 0; i < n; i++) ld_words[i] = $urandom;
    wa_q.delete();
    wd_q.delete();
    while (acc < n && cyc < 2 * n + 40) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.ld_valid = v;
      bus.ld_data  = ld_words[acc];
      bus.ld_last  = (acc == last_idx);
      sample();
      if (s_we !== (v & s_ready)) we_bad++;
      if (acc >= DEPTH && s_ready !== 1'b0) full_bad++;
      @(posedge clk);
      if (v && s_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n, input int last_idx, input int acc);
    int exp_acc;
    exp_acc = (last_idx >= 0) ? last_idx + 1 : n;
    if (exp_acc > DEPTH) exp_acc = DEPTH;
    for (int i = 0; i < exp_acc; i++) exp_mem[i] = ld_words[i];
    chk({tag, "_acc"}, acc, exp_acc);
    chk({tag, "_we_on_hs"}, we_bad, 0);
    chk({tag, "_nwr"}, wa_q.size(), exp_acc);
    chk_log({tag, "_log"}, 0, exp_acc, 1'b0);
    chk({tag, "_cnt"}, load_cnt, exp_acc);
    chk({tag, "_stall"}, bus.cpu_stall, 1'b0);
    chk({tag, "_ready"}, bus.ld_ready, 1'b0);
    chk({tag, "_we_run"}, bus.mem_we, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.cpu_addr = mk_addr(i);
      #1;
      chk({tag, "_fetch"}, bus.cpu_instr, exp_mem[i]);
    end
    bus.cpu_addr = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first_ready, n;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0;
    bus.ld_last  = 1'b0;
    bus.cpu_addr = 32'h8;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ld_ready, 1'b0);
    chk("rst_stall", bus.cpu_stall, 1'b1);
    chk("rst_instr", bus.cpu_instr, 32'h0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_cnt", load_cnt, 0);
`ifdef IMEM_FETCH_CHECK_EN
    chk("rst_ferr", fetch_err, 1'b0);
`endif

    // Zero-fill after reset: 70 cycles observed
    rst_n = 1'b1;
    first_ready = 0;
    stall_bad   = 0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (s_ready === 1'b1 && first_ready == 0) first_ready = c;
      if (c <= DEPTH && s_stall !== 1'b1) stall_bad++;
    end
    chk("clr0_first_load", first_ready, DEPTH + 1);
    chk("clr0_stall", stall_bad, 0);
    chk("clr0_nwr", wa_q.size(), DEPTH);
    chk_log("clr0_log", 0, DEPTH, 1'b1);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;

    // Fixed three-word program
    ld_words[0] = 32'h2008_0005;
    ld_words[1] = 32'h2009_0003;
    ld_words[2] = 32'h0109_5020;
    do_load(3, 2, 0, 1'b1, acc);
    bus.cpu_addr = 32'h8;
    #1;
    chk("p3_addr8", bus.cpu_instr, 32'h0109_5020);
    @(negedge clk);
    check_run("p3", 3, 2, acc);

`ifdef IMEM_FETCH_CHECK_EN
    bus.cpu_addr = 32'h6;
    #1;
    chk("ferr_mis_instr", bus.cpu_instr, 32'h0);
    @(negedge clk);
    chk("ferr_mis_flag", fetch_err, 1'b1);
    bus.cpu_addr = 32'h0;
    #1;
    chk("ferr_sticky", fetch_err, 1'b1);
    chk("ferr_ok_instr", bus.cpu_instr, exp_mem[0]);
    @(negedge clk);
`endif

    // Valid toggling 1-0-1 with four words
    reload_clear("tg");
`ifdef IMEM_FETCH_CHECK_EN
    chk("ferr_reload", fetch_err, 1'b0);
`endif
    do_load(4, 3, 1, 1'b0, acc);
    check_run("tg", 4, 3, acc);

`ifdef IMEM_FETCH_CHECK_EN
    bus.cpu_addr = 32'h100;
    #1;
    chk("ferr_oob_instr", bus.cpu_instr, 32'h0);
    @(negedge clk);
    chk("ferr_oob_flag", fetch_err, 1'b1);
    bus.cpu_addr = 32'h0;
`endif

    // Random-length program with random valid gaps
    reload_clear("rnd");
    n = $urandom_range(5, 40);
    do_load(n, n - 1, 2, 1'b0, acc);
    check_run("rnd", n, n - 1, acc);

    // Single-word program
    reload_clear("one");
    do_load(1, 0, 0, 1'b0, acc);
    check_run("one", 1, 0, acc);

    // Overlong stream without ld_last fills memory
    reload_clear("full");
    do_load(70, -1, 0, 1'b0, acc);
    chk("full_ready_off", full_bad, 0);
    check_run("full", 70, -1, acc);

    // reload coincides with the handshake of word 2
    reload_clear("rlhs");
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < 3; i++) ld_words[i] = $urandom;
    bus.ld_valid = 1'b1;
    bus.ld_data  = ld_words[0];
    tick();
    bus.ld_data  = ld_words[1];
    tick();
    bus.ld_data  = ld_words[2];
    reload       = 1'b1;
    sample();
    chk("rlhs_we", s_we, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reload       = 1'b0;
    bus.ld_valid = 1'b0;
    chk("rlhs_nwr", wa_q.size(), 2);
    chk_log("rlhs_log", 0, 2, 1'b0);
    chk("rlhs_cnt", load_cnt, 0);
    chk("rlhs_stall", bus.cpu_stall, 1'b1);
    chk("rlhs_ready", bus.ld_ready, 1'b0);
    wa_q.delete();
    wd_q.delete();
    wait_clear("rlhs");
    chk_log("rlhs_clr_log", 0, DEPTH, 1'b1);
    do_load(2, 1, 0, 1'b0, acc);
    check_run("rlhs_post", 2, 1, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
